reset_stretcher: RTL and testbench

RESET_STRETCHER -- requirements
Module: reset_stretcher

---
 rtl/reset_stretcher_pkg.sv | 22 ++
 rtl/reset_stretcher.sv | 113 +++++++++++
 tb/tb_reset_stretcher.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/reset_stretcher_pkg.sv
// Shared definitions for the reset stretcher.
//   state_t   : FSM encoding (IDLE/HOLD/SETTLE)
//   CNT_W     : width of the in-state cycle counter
//   EVENT_W   : width of the episode counter
//   sat_inc() : saturating increment for the episode counter
package reset_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam int CNT_W   = 16;
    localparam int EVENT_W = 8;

    // Sticks at all-ones instead of wrapping back to zero.
    function automatic logic [EVENT_W-1:0] sat_inc(input logic [EVENT_W-1:0] value);
        return (value == {EVENT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/reset_stretcher.sv
// Reset stretcher: turns a level-sensitive reset request into a reset pulse
// held RSTDELAY cycles past the last request, followed by a QUIET-cycle
// settle window before READY is raised.
//
// Ports
//   CLK         : clock, all state updates on the rising edge
//   RST         : synchronous active-high block reset
//   ASSERT_IN   : level-sensitive reset request
//   RESET_OUT   : stretched active-high reset (registered, high in HOLD)
//   READY       : high only in IDLE (registered)
//   EVENT_COUNT : saturating count of reset episodes started
module reset_stretcher
    import reset_stretcher_pkg::*;
#(
    parameter int RSTDELAY = 2,
    parameter int QUIET    = 4,
    parameter bit INIT     = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ASSERT_IN,
    output logic               RESET_OUT,
    output logic               READY,
    output logic [EVENT_W-1:0] EVENT_COUNT
);

    // Reject out-of-range parameters at elaboration time.
    generate
        if ((RSTDELAY < 1) || (RSTDELAY > 65535)) begin : g_bad_rstdelay
            $fatal(1, "reset_stretcher: RSTDELAY must be in 1..65535");
        end
        if ((QUIET < 1) || (QUIET > 65535)) begin : g_bad_quiet
            $fatal(1, "reset_stretcher: QUIET must be in 1..65535");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RSTDELAY - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(QUIET - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [EVENT_W-1:0] event_reg, event_next;
    logic               reset_out_reg;
    logic               ready_reg;

    // Next-state, counter and episode-count logic. The counter restarts at
    // zero on every state entry and on a HOLD retrigger.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        event_next = event_reg;
        case (state_reg)
            IDLE: begin
                if (ASSERT_IN) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                    event_next = sat_inc(event_reg);
                end
            end
            HOLD: begin
                if (ASSERT_IN) begin
                    // Retrigger: same episode, so the event count stays put.
                    cnt_next = '0;
                end else if (cnt_reg >= HOLD_LAST) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SETTLE: begin
                if (ASSERT_IN) begin
                    // A request while settling starts a fresh episode.
                    state_next = HOLD;
                    cnt_next   = '0;
                    event_next = sat_inc(event_reg);
                end else if (cnt_reg >= SETTLE_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register without an extra cycle of delay.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= INIT ? HOLD : IDLE;
            cnt_reg       <= '0;
            event_reg     <= '0;
            reset_out_reg <= INIT;
            ready_reg     <= ~INIT;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            event_reg     <= event_next;
            reset_out_reg <= (state_next == HOLD);
            ready_reg     <= (state_next == IDLE);
        end
    end

    assign RESET_OUT   = reset_out_reg;
    assign READY       = ready_reg;
    assign EVENT_COUNT = event_reg;

endmodule

// File: tb/tb_reset_stretcher.sv
module tb_reset_stretcher;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, a0 = 1'b0;
    logic       rst1 = 1'b1, a1 = 1'b0;
    logic       ro0, rdy0, ro1, rdy1;
    logic [7:0] ec0, ec1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         which;
        bit         chk;
        logic       ro;
        logic       rdy;
        logic [7:0] ec;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reset_stretcher #(.RSTDELAY(2), .QUIET(4), .INIT(1'b0)) dut0 (
        .CLK(clk), .RST(rst0), .ASSERT_IN(a0),
        .RESET_OUT(ro0), .READY(rdy0), .EVENT_COUNT(ec0)
    );

    reset_stretcher #(.RSTDELAY(2), .QUIET(4), .INIT(1'b1)) dut1 (
        .CLK(clk), .RST(rst1), .ASSERT_IN(a1),
        .RESET_OUT(ro1), .READY(rdy1), .EVENT_COUNT(ec1)
    );

    // One cycle on dut0; the entry describes outputs after the coming edge.
    task automatic t0(input logic r, input logic a, input logic ro, input logic rdy,
                      input logic [7:0] ec, input bit chk, input string name);
        exp_t e;
        @(negedge clk);
        rst0 = r; a0 = a; rst1 = 1'b0; a1 = 1'b0;
        e.which = 1'b0; e.chk = chk; e.ro = ro; e.rdy = rdy; e.ec = ec; e.name = name;
        sb.push_back(e);
    endtask

    task automatic t1(input logic r, input logic a, input logic ro, input logic rdy,
                      input logic [7:0] ec, input string name);
        exp_t e;
        @(negedge clk);
        rst1 = r; a1 = a; rst0 = 1'b1; a0 = 1'b0;
        e.which = 1'b1; e.chk = 1'b1; e.ro = ro; e.rdy = rdy; e.ec = ec; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per clock and compares the sampled outputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                logic       ro, rdy;
                logic [7:0] ec;
                e = sb.pop_front();
                ro  = e.which ? ro1  : ro0;
                rdy = e.which ? rdy1 : rdy0;
                ec  = e.which ? ec1  : ec0;
                if (e.chk) begin
                    checks++;
                    if (ro !== e.ro || rdy !== e.rdy || ec !== e.ec) begin
                        errors++;
                        $display("FAIL %s: got ro=%b rdy=%b ec=%0d, expected ro=%b rdy=%b ec=%0d",
                                 e.name, ro, rdy, ec, e.ro, e.rdy, e.ec);
                    end else begin
                        $display("ok   %s: ro=%b rdy=%b ec=%0d", e.name, ro, rdy, ec);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_ec;

        // Power-up with INIT=1: held in HOLD under RST, then 2 cycles of
        // reset, 4 settle cycles, then READY.
        repeat (3) t1(1, 0, 1, 0, 0, "pwr_rst");
        t1(0, 0, 1, 0, 0, "pwr_hold2");
        repeat (4) t1(0, 0, 0, 0, 0, "pwr_settle");
        t1(0, 0, 0, 1, 0, "pwr_ready");
        t1(0, 0, 0, 1, 0, "pwr_idle");
        t1(0, 1, 1, 0, 1, "pwr_first_event");

        // INIT=0 reset state.
        repeat (2) t0(1, 0, 0, 1, 0, 1, "init0_rst");
        repeat (3) t0(0, 0, 0, 1, 0, 1, "idle");

        // Single pulse.
        t0(0, 1, 1, 0, 1, 1, "pulse_hold0");
        t0(0, 0, 1, 0, 1, 1, "pulse_hold1");
        repeat (4) t0(0, 0, 0, 0, 1, 1, "pulse_settle");
        t0(0, 0, 0, 1, 1, 1, "pulse_ready");

        // Retrigger on consecutive cycles.
        t0(1, 0, 0, 1, 0, 1, "rst");
        t0(0, 1, 1, 0, 1, 1, "retrig_a");
        t0(0, 1, 1, 0, 1, 1, "retrig_b");
        t0(0, 0, 1, 0, 1, 1, "retrig_tail");
        repeat (4) t0(0, 0, 0, 0, 1, 1, "retrig_settle");
        t0(0, 0, 0, 1, 1, 1, "retrig_ready");

        // Restart during SETTLE.
        t0(1, 0, 0, 1, 0, 1, "rst");
        t0(0, 1, 1, 0, 1, 1, "restart_p1");
        t0(0, 0, 1, 0, 1, 1, "restart_hold1");
        t0(0, 0, 0, 0, 1, 1, "restart_settle0");
        t0(0, 0, 0, 0, 1, 1, "restart_settle1");
        t0(0, 1, 1, 0, 2, 1, "restart_p2");
        t0(0, 0, 1, 0, 2, 1, "restart_hold1b");
        repeat (4) t0(0, 0, 0, 0, 2, 1, "restart_settleb");
        t0(0, 0, 0, 1, 2, 1, "restart_ready");

        // Held request keeps reset asserted without counting.
        t0(1, 0, 0, 1, 0, 1, "rst");
        repeat (20) t0(0, 1, 1, 0, 1, 1, "held");
        t0(0, 0, 1, 0, 1, 1, "held_release");
        t0(0, 0, 0, 0, 1, 1, "held_settle");

        // RST during SETTLE, with ASSERT_IN high: RST wins.
        t0(1, 1, 0, 1, 0, 1, "rst_mid_settle");

        // RST during HOLD.
        t0(0, 1, 1, 0, 1, 1, "mid_hold_pulse");
        t0(1, 0, 0, 1, 0, 1, "rst_mid_hold");

        // Saturation: 300 isolated pulses.
        for (int i = 1; i <= 300; i++) begin
            exp_ec = (i > 255) ? 8'd255 : 8'(i);
            t0(0, 1, 1, 0, exp_ec, 1, "sat_pulse");
            repeat (5) t0(0, 0, 0, 0, 0, 0, "sat_gap");
            t0(0, 0, 0, 1, exp_ec, 1, "sat_idle");
        end
        repeat (3) t0(0, 0, 0, 1, 255, 1, "sat_hold");

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
